// File: rtl/reset_sequencer.sv
// reset_sequencer
// Releases N_STAGES reset domains in fixed order after power-on or any reset
// request. All domains stay low for MIN_HOLD cycles. The block then waits for
// the oscillator-stable flag, or gives up after OSC_TIMEOUT cycles. After that
// one domain is released every STAGE_GAP cycles. The cause of the most recent
// reset is kept in rst_cause.
//
// Handshake/interface semantics: there is no valid/ready traffic here.
//  - wdt_req and sw_req are clk_RC-synchronous levels. Any cycle in which one
//    of them is high counts as a request. A one-cycle pulse is enough.
//  - ext_rst_n and osc_ok are asynchronous. They pass through 2-FF
//    synchronizers before any logic uses them.
//  - A request forces every domain low on the next edge, whatever state the
//    block is in. No sequencing is in progress after that edge.
module reset_sequencer #(
  parameter int N_STAGES    = 3,
  parameter int MIN_HOLD    = 16,
  parameter int STAGE_GAP   = 8,
  parameter int OSC_TIMEOUT = 1024
) (
  input  logic                clk_RC,
  input  logic                POR_n,
  input  logic                ext_rst_n,
  input  logic                osc_ok,
  input  logic                wdt_req,
  input  logic                sw_req,
  output logic [N_STAGES-1:0] rst_stage_n,
  output logic [1:0]          rst_cause,
  output logic                osc_fail,
  output logic                seq_done,
  output logic [1:0]          state_dbg
);

  localparam int MAX_AB  = (MIN_HOLD > STAGE_GAP) ? MIN_HOLD : STAGE_GAP;
  localparam int CNT_MAX = (MAX_AB > OSC_TIMEOUT) ? MAX_AB : OSC_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SW      = $clog2(N_STAGES + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] OSC_LAST   = CW'(OSC_TIMEOUT - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(N_STAGES - 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;
  localparam logic [1:0] CAUSE_SW  = 2'b11;

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_WAIT_OSC = 2'd1,
    S_RELEASE  = 2'd2,
    S_RUN      = 2'd3
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [SW-1:0]       stage;
  logic                ext_meta;
  logic                ext_s;
  logic                osc_meta;
  logic                osc_s;
  logic                ext_armed;
  logic                req;
  logic [1:0]          next_cause;
  logic [N_STAGES-1:0] release_mask;

  assign state_dbg = state;

  // Two-flop synchronizers for the asynchronous inputs.
  // ext_armed records that the synchronized ext_rst_n has been seen high at
  // least once since power-on. The synchronizer powers up at 0, so without
  // this flag that reset value would be logged as an external reset.
  always_ff @(posedge clk_RC or negedge POR_n) begin
    if (!POR_n) begin
      ext_meta  <= 1'b0;
      ext_s     <= 1'b0;
      osc_meta  <= 1'b0;
      osc_s     <= 1'b0;
      ext_armed <= 1'b0;
    end else begin
      ext_meta  <= ext_rst_n;
      ext_s     <= ext_meta;
      osc_meta  <= osc_ok;
      osc_s     <= osc_meta;
      ext_armed <= ext_armed | ext_s;
    end
  end

  // Request merge, cause priority (EXT > WDT > SW), and one-hot mask of the
  // stage to be released next.
  always_comb begin
    req        = ~ext_s | wdt_req | sw_req;
    next_cause = rst_cause;
    if (~ext_s && ext_armed) begin
      next_cause = CAUSE_EXT;
    end else if (wdt_req) begin
      next_cause = CAUSE_WDT;
    end else if (sw_req) begin
      next_cause = CAUSE_SW;
    end
    release_mask = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      release_mask[i] = (stage == SW'(i));
    end
  end

  // Sequencer FSM. A request overrides every state. All outputs are registered.
  always_ff @(posedge clk_RC or negedge POR_n) begin
    if (!POR_n) begin
      state       <= S_HOLD;
      cnt         <= '0;
      stage       <= '0;
      rst_stage_n <= '0;
      rst_cause   <= CAUSE_POR;
      osc_fail    <= 1'b0;
      seq_done    <= 1'b0;
    end else if (req) begin
      state       <= S_HOLD;
      cnt         <= '0;
      stage       <= '0;
      rst_stage_n <= '0;
      seq_done    <= 1'b0;
      rst_cause   <= next_cause;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= S_WAIT_OSC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_OSC: begin
          if (osc_s) begin
            state    <= S_RELEASE;
            cnt      <= '0;
            osc_fail <= 1'b0;
          end else if (cnt == OSC_LAST) begin
            state    <= S_RELEASE;
            cnt      <= '0;
            osc_fail <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (cnt == GAP_LAST) begin
            cnt         <= '0;
            rst_stage_n <= rst_stage_n | release_mask;
            stage       <= stage + 1'b1;
            if (stage == STAGE_LAST) begin
              state    <= S_RUN;
              seq_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          seq_done <= 1'b1;
        end
        default: begin
          state       <= S_HOLD;
          cnt         <= '0;
          stage       <= '0;
          rst_stage_n <= '0;
          seq_done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed bench for reset_sequencer with default parameters. It steps a fixed
// number of clk_RC edges and compares the outputs 1 time unit after the edge
// against hand-derived cycle counts.
module tb_reset_sequencer;

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  logic       clk_RC;
  logic       POR_n;
  logic       ext_rst_n;
  logic       osc_ok;
  logic       wdt_req;
  logic       sw_req;
  logic [2:0] rst_stage_n;
  logic [1:0] rst_cause;
  logic       osc_fail;
  logic       seq_done;
  logic [1:0] state_dbg;

  int n_total = 0;
  int n_bad   = 0;

  reset_sequencer #(
    .N_STAGES(3), .MIN_HOLD(16), .STAGE_GAP(8), .OSC_TIMEOUT(1024)
  ) dut (
    .clk_RC      (clk_RC),
    .POR_n       (POR_n),
    .ext_rst_n   (ext_rst_n),
    .osc_ok      (osc_ok),
    .wdt_req     (wdt_req),
    .sw_req      (sw_req),
    .rst_stage_n (rst_stage_n),
    .rst_cause   (rst_cause),
    .osc_fail    (osc_fail),
    .seq_done    (seq_done),
    .state_dbg   (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk_RC = 1'b0;
    forever #5 clk_RC = ~clk_RC;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Driver / checking tasks
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_RC);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] rst, input logic done,
                           input logic [1:0] cause);
    check_eq({tag, ".rst"}, rst_stage_n, rst);
    check_eq({tag, ".done"}, seq_done, done);
    check_eq({tag, ".cause"}, rst_cause, cause);
  endtask

  task automatic por_release;
    @(negedge clk_RC);
    POR_n = 1'b1;
  endtask

  initial begin
    logic held_ok;
    POR_n = 1'b0; ext_rst_n = 1'b1; osc_ok = 1'b1; wdt_req = 1'b0; sw_req = 1'b0;
    #12;
    // Reset state
    check_out("por", 3'b000, 1'b0, 2'b00);
    check_eq("por.osc_fail", osc_fail, 1'b0);
    check_eq("por.state", state_dbg, ST_HOLD);

    // 1: POR release with osc_ok high
    por_release();
    step(17); check_eq("s1.e17.state", state_dbg, ST_HOLD);
    step(1);  check_eq("s1.e18.state", state_dbg, ST_WAIT);
    step(1);  check_eq("s1.e19.state", state_dbg, ST_REL);
    step(7);  check_out("s1.e26", 3'b000, 1'b0, 2'b00);
    step(1);  check_out("s1.e27", 3'b001, 1'b0, 2'b00);
    step(7);  check_out("s1.e34", 3'b001, 1'b0, 2'b00);
    step(1);  check_out("s1.e35", 3'b011, 1'b0, 2'b00);
    step(7);  check_out("s1.e42", 3'b011, 1'b0, 2'b00);
    step(1);  check_out("s1.e43", 3'b111, 1'b1, 2'b00);
    check_eq("s1.osc_fail", osc_fail, 1'b0);
    check_eq("s1.state", state_dbg, ST_RUN);

    // osc_ok dropping in RUN has no effect
    osc_ok = 1'b0;
    step(6);  check_out("osc_drop", 3'b111, 1'b1, 2'b00);
    osc_ok = 1'b1;

    // 3: one-cycle ext_rst_n pulse in RUN, latency 3 edges
    ext_rst_n = 1'b0;
    step(1); ext_rst_n = 1'b1;
    check_out("s3.a1", 3'b111, 1'b1, 2'b00);
    step(1); check_out("s3.a2", 3'b111, 1'b1, 2'b00);
    step(1); check_out("s3.a3", 3'b000, 1'b0, 2'b01);
    step(24); check_out("s3.a27", 3'b000, 1'b0, 2'b01);
    step(1);  check_out("s3.a28", 3'b001, 1'b0, 2'b01);
    step(16); check_out("s3.a44", 3'b111, 1'b1, 2'b01);

    // 3b: ext_rst_n held low ~100 cycles keeps HOLD
    ext_rst_n = 1'b0;
    step(2); check_out("s3b.b2", 3'b111, 1'b1, 2'b01);
    step(1); check_out("s3b.b3", 3'b000, 1'b0, 2'b01);
    held_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (state_dbg !== ST_HOLD || rst_stage_n !== 3'b000) held_ok = 1'b0;
    end
    check_eq("s3b.held", held_ok, 1'b1);
    ext_rst_n = 1'b1;
    step(26); check_out("s3b.c26", 3'b000, 1'b0, 2'b01);
    step(1);  check_out("s3b.c27", 3'b001, 1'b0, 2'b01);
    step(16); check_out("s3b.c43", 3'b111, 1'b1, 2'b01);

    // 4: wdt and sw in the same cycle -> WDT wins
    wdt_req = 1'b1; sw_req = 1'b1;
    step(1); wdt_req = 1'b0; sw_req = 1'b0;
    check_out("s4.d1", 3'b000, 1'b0, 2'b10);
    step(40); check_out("s4.d41", 3'b011, 1'b0, 2'b10);
    step(1);  check_out("s4.d42", 3'b111, 1'b1, 2'b10);

    // 4b: sw alone
    sw_req = 1'b1;
    step(1); sw_req = 1'b0;
    check_out("s4b.d1", 3'b000, 1'b0, 2'b11);

    // 5: sw_req while only bit 0 released
    step(25); check_out("s5.d26", 3'b001, 1'b0, 2'b11);
    check_eq("s5.d26.state", state_dbg, ST_REL);
    step(3);  check_out("s5.d29", 3'b001, 1'b0, 2'b11);
    sw_req = 1'b1;
    step(1); sw_req = 1'b0;
    check_out("s5.f1", 3'b000, 1'b0, 2'b11);
    check_eq("s5.f1.state", state_dbg, ST_HOLD);
    step(24); check_out("s5.f25", 3'b000, 1'b0, 2'b11);
    step(1);  check_out("s5.f26", 3'b001, 1'b0, 2'b11);
    step(16); check_out("s5.f42", 3'b111, 1'b1, 2'b11);

    // 2: osc_ok held low -> timeout release
    POR_n = 1'b0; osc_ok = 1'b0;
    #2;
    check_out("s2.por", 3'b000, 1'b0, 2'b00);
    por_release();
    step(18);   check_eq("s2.e18.state", state_dbg, ST_WAIT);
    step(1023); check_eq("s2.e1041.state", state_dbg, ST_WAIT);
    check_eq("s2.e1041.osc_fail", osc_fail, 1'b0);
    step(1);    check_eq("s2.e1042.state", state_dbg, ST_REL);
    check_eq("s2.e1042.osc_fail", osc_fail, 1'b1);
    step(7);    check_out("s2.e1049", 3'b000, 1'b0, 2'b00);
    step(1);    check_out("s2.e1050", 3'b001, 1'b0, 2'b00);
    step(8);    check_out("s2.e1058", 3'b011, 1'b0, 2'b00);
    step(8);    check_out("s2.e1066", 3'b111, 1'b1, 2'b00);
    check_eq("s2.e1066.osc_fail", osc_fail, 1'b1);

    // osc_fail survives a request, replay times out again
    sw_req = 1'b1;
    step(1); sw_req = 1'b0;
    check_out("s2b.g1", 3'b000, 1'b0, 2'b11);
    check_eq("s2b.g1.osc_fail", osc_fail, 1'b1);
    step(1048); check_out("s2b.g1049", 3'b001, 1'b0, 2'b11);
    step(3);    check_eq("s2b.g1052.state", state_dbg, ST_REL);

    // 6: asynchronous POR mid-RELEASE
    POR_n = 1'b0;
    #2;
    check_out("s6.async", 3'b000, 1'b0, 2'b00);
    check_eq("s6.async.osc_fail", osc_fail, 1'b0);
    check_eq("s6.async.state", state_dbg, ST_HOLD);
    step(2);
    check_out("s6.held", 3'b000, 1'b0, 2'b00);
    osc_ok = 1'b1;
    por_release();
    step(26); check_out("s6.e26", 3'b000, 1'b0, 2'b00);
    step(1);  check_out("s6.e27", 3'b001, 1'b0, 2'b00);
    step(16); check_out("s6.e43", 3'b111, 1'b1, 2'b00);
    check_eq("s6.e43.osc_fail", osc_fail, 1'b0);

    // Final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
